compressor_tree_pipe_n_bit: RTL

//   Parametrised, pipelined carry-save reduction tree: NUM_INPUTS operands -> sum/carry pair

---
 rtl/compressor_tree_pipe_n_bit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/compressor_tree_pipe_n_bit.sv
// Pipelined carry-save reduction tree: NUM_INPUTS operands reduced by 4:2 compressor
// levels to a sum/carry pair, with optional per-level registers and a valid/ready handshake.
module compressor_tree_pipe_n_bit #(
  parameter int         NUM_INPUTS   = 8,
  parameter int         INPUT_WIDTH  = 12,
  parameter int         OUTPUT_WIDTH = 16,
  parameter bit         SHIFT_CARRY  = 1'b1,
  parameter logic [3:0] REG_MASK     = 4'hF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [INPUT_WIDTH-1:0]  operands_i [NUM_INPUTS],
  input  logic                    is_signed_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [OUTPUT_WIDTH-1:0] sum_o,
  output logic [OUTPUT_WIDTH-1:0] carry_o,
  output logic [OUTPUT_WIDTH-1:0] result_o
);

  localparam int LEVELS = $clog2(NUM_INPUTS) - 1;
  localparam int WL     = INPUT_WIDTH + 2 * LEVELS;
  // Carry-save pairs are only congruent to the true sum modulo their width, so every
  // level works at the final width; operands are extended once, on entry, per is_signed.
  localparam int WF     = (WL > OUTPUT_WIDTH) ? WL : OUTPUT_WIDTH;

  logic [LEVELS-1:0] stage_vld;
  logic [LEVELS:0]   vld_at;
  logic [LEVELS:0]   rdy_at;

  // Handshake chain: combinational levels pass valid/ready straight through.
  always_comb begin
    vld_at         = '0;
    rdy_at         = '0;
    vld_at[0]      = valid_i;
    for (int k = 0; k < LEVELS; k++) begin
      vld_at[k+1] = REG_MASK[k] ? stage_vld[k] : vld_at[k];
    end
    rdy_at[LEVELS] = ready_i;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      rdy_at[k] = (REG_MASK[k] && !stage_vld[k]) || rdy_at[k+1];
    end
  end

  genvar gi, gj;
  for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
    localparam int NI = NUM_INPUTS >> gi;
    localparam int NO = NI / 2;

    logic [WF-1:0] in_w  [NI];
    logic [WF-1:0] lvl_d [NO];
    logic [WF-1:0] out_w [NO];

    if (gi == 0) begin : g_src
      for (gj = 0; gj < NI; gj++) begin : g_ext
        assign in_w[gj] = {{(WF-INPUT_WIDTH){is_signed_i & operands_i[gj][INPUT_WIDTH-1]}},
                           operands_i[gj]};
      end
    end else begin : g_src
      for (gj = 0; gj < NI; gj++) begin : g_fwd
        assign in_w[gj] = g_lvl[gi-1].out_w[gj];
      end
    end

    // 4:2 compressor as two chained 3:2 rows; outputs are (sum, aligned carry) pairs.
    for (gj = 0; gj < NO / 2; gj++) begin : g_cmp
      logic [WF-1:0] s1;
      logic [WF-1:0] c1;
      assign s1 = in_w[4*gj] ^ in_w[4*gj+1] ^ in_w[4*gj+2];
      assign c1 = ((in_w[4*gj] & in_w[4*gj+1]) | (in_w[4*gj] & in_w[4*gj+2]) |
                   (in_w[4*gj+1] & in_w[4*gj+2])) << 1;
      assign lvl_d[2*gj]   = s1 ^ c1 ^ in_w[4*gj+3];
      assign lvl_d[2*gj+1] = ((s1 & c1) | (s1 & in_w[4*gj+3]) | (c1 & in_w[4*gj+3])) << 1;
    end

    if (REG_MASK[gi]) begin : g_stage
      logic          vld_q;
      logic [WF-1:0] data_q [NO];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_q <= 1'b0;
          for (int j = 0; j < NO; j++) begin
            data_q[j] <= '0;
          end
        end else begin
          if (flush_i) begin
            vld_q <= 1'b0;
          end else if (rdy_at[gi]) begin
            vld_q <= vld_at[gi];
          end
          if (rdy_at[gi] && vld_at[gi]) begin
            data_q <= lvl_d;
          end
        end
      end

      assign stage_vld[gi] = vld_q;
      assign out_w         = data_q;
    end else begin : g_stage
      assign stage_vld[gi] = 1'b0;
      assign out_w         = lvl_d;
    end
  end

  logic [WF-1:0] fin_sum;
  logic [WF-1:0] fin_carry;
  logic [WF-1:0] carry_half;

  assign fin_sum    = g_lvl[LEVELS-1].out_w[0];
  assign fin_carry  = g_lvl[LEVELS-1].out_w[1];
  // The final carry always has a zero LSB, so halving it loses nothing.
  assign carry_half = fin_carry >> 1;

  assign sum_o    = fin_sum[OUTPUT_WIDTH-1:0];
  assign carry_o  = SHIFT_CARRY ? fin_carry[OUTPUT_WIDTH-1:0] : carry_half[OUTPUT_WIDTH-1:0];
  assign result_o = fin_sum[OUTPUT_WIDTH-1:0] + fin_carry[OUTPUT_WIDTH-1:0];
  assign valid_o  = vld_at[LEVELS];
  assign ready_o  = rdy_at[0];

endmodule
